// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// write-enable constants and the address range/alignment check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] DMEM_WEN_READ = 4'b0000;
  localparam logic [3:0] DMEM_WEN_WORD = 4'b1111;

  // 33-bit compare so a window ending at 2^32 does not wrap.
  function automatic logic dmem_addr_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          depth_words);
    logic [32:0] a_ext;
    logic [32:0] lo_ext;
    logic [32:0] hi_ext;
    a_ext  = {1'b0, addr};
    lo_ext = {1'b0, base};
    hi_ext = lo_ext + (33'(depth_words) * 33'd4);
    return (addr[1:0] != 2'b00) || (a_ext < lo_ext) || (a_ext >= hi_ext);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte-lane write enables and a registered read
// port (read-before-write). Contents are intentionally not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, waits WAIT_CYCLES,
// commits to dmem_array and pulses mem_resp, stalling the pipeline meanwhile.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        mem_stall
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]    rst_sync_q;
  logic          rst_n_s;
  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    wen_q, wen_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_q, resp_d;
  logic          err_q, err_d;
  logic          rd_ok_q, rd_ok_d;
  logic [3:0]    req_wen_s;
  logic [31:0]   req_addr_s;
  logic [31:0]   req_wdata_s;
  logic          req_err_s;
  logic          commit_s;
  logic [3:0]    we_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   arr_rdata_s;

  // Assert asynchronously, release two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  // With zero wait states the commit happens in IDLE, so the array must see
  // the live request rather than the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      req_wen_s   = mem_wen;
      req_addr_s  = mem_addr;
      req_wdata_s = mem_wdata;
    end else begin
      req_wen_s   = wen_q;
      req_addr_s  = addr_q;
      req_wdata_s = wdata_q;
    end
    req_err_s = dmem_addr_err(req_addr_s, BASE_ADDR, DEPTH_WORDS);
    idx_s     = AW'((req_addr_s - BASE_ADDR) >> 2);
  end

  // Next-state, counter, request latch and response flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          wen_d   = mem_wen;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            commit_s = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit_s = 1'b1;
          state_d  = RESP;
        end else begin
          state_d  = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_d  = commit_s;
    err_d   = commit_s && req_err_s;
    rd_ok_d = commit_s && !req_err_s && (req_wen_s == DMEM_WEN_READ);
    if (commit_s && !req_err_s && rst_n_s) begin
      we_s = req_wen_s;
    end else begin
      we_s = DMEM_WEN_READ;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (we_s),
    .idx  (idx_s),
    .wdata(req_wdata_s),
    .rdata(arr_rdata_s)
  );

  assign mem_resp  = resp_q;
  assign mem_err   = err_q;
  assign mem_rdata = rd_ok_q ? arr_rdata_s : 32'h0000_0000;
  assign mem_stall = ((state_q == IDLE) && mem_en) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one
// with none, driven through a shared request bus selected by sel.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        en  = 1'b0;
  logic [3:0]  wen = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        en_a, en_b;
  logic [31:0] rdata_a, rdata_b, rdata_m;
  logic        resp_a, resp_b, resp_m;
  logic        err_a, err_b, err_m;
  logic        stall_a, stall_b, stall_m;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign en_a    = en & ~sel;
  assign en_b    = en & sel;
  assign rdata_m = sel ? rdata_b : rdata_a;
  assign resp_m  = sel ? resp_b  : resp_a;
  assign err_m   = sel ? err_b   : err_a;
  assign stall_m = sel ? stall_b : stall_a;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .mem_en(en_a), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata_a), .mem_resp(resp_a), .mem_err(err_a),
    .mem_stall(stall_a)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) dut_b (
    .clk(clk), .rst(rst), .mem_en(en_b), .mem_wen(wen), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata_b), .mem_resp(resp_b), .mem_err(err_b),
    .mem_stall(stall_b)
  );

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request from a negedge; reports response latency (cycles after the
  // request cycle), stalled cycle count and the response payload.
  task automatic run_req(input logic s, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic drop,
                         output int lat, output int stalls,
                         output logic [31:0] rd, output logic er);
    bit done;
    done = 1'b0; lat = -1; stalls = 0; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    sel = s; wen = w; addr = a; wdata = d; en = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (stall_m) stalls++;
      if (resp_m) begin
        lat = k; rd = rdata_m; er = err_m; done = 1'b1; en = 1'b0;
      end else begin
        if (drop && k == 1) en = 1'b0;
        @(negedge clk);
      end
    end
    check("resp_timeout", 32'(done), 32'd1);
  endtask

  vec_t        vecs [15];
  int          lat, stalls;
  logic [31:0] rd;
  logic        er;

  initial begin
    vecs[0]  = '{4'b1111, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{4'b0000, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{4'b0100, 32'h10,   32'h00AB0000, 32'h0,        1'b0};
    vecs[3]  = '{4'b0000, 32'h10,   32'h0,        32'hDEABBEEF, 1'b0};
    vecs[4]  = '{4'b0000, 32'h12,   32'h0,        32'h0,        1'b1};
    vecs[5]  = '{4'b0000, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{4'b0000, 32'h10,   32'h0,        32'hDEABBEEF, 1'b0};
    vecs[7]  = '{4'b1111, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0};
    vecs[8]  = '{4'b1111, 32'h1000, 32'h12345678, 32'h0,        1'b1};
    vecs[9]  = '{4'b0000, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
    vecs[10] = '{4'b1111, 32'h11,   32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[11] = '{4'b0000, 32'h10,   32'h0,        32'hDEABBEEF, 1'b0};
    vecs[12] = '{4'b1111, 32'hFFC,  32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[13] = '{4'b0000, 32'hFFC,  32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[14] = '{4'b1111, 32'h20,   32'h11111111, 32'h0,        1'b0};

    // Outputs clear on reset assertion with no clock edge.
    en = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_resp",  32'(resp_a),  32'd0);
    check("rst_err",   32'(err_a),   32'd0);
    check("rst_rdata", rdata_a,      32'd0);
    check("rst_stall", 32'(stall_a), 32'd1);
    en = 1'b0;
    #1;
    check("rst_stall_idle", 32'(stall_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_req(1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, 1'b0, lat, stalls, rd, er);
      check($sformatf("v%0d_lat", i),   32'(lat),    32'd3);
      check($sformatf("v%0d_stall", i), 32'(stalls), 32'd3);
      check($sformatf("v%0d_rdata", i), rd,          vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i),   32'(er),     32'(vecs[i].exp_err));
    end

    // Reset in the middle of WAIT drops the pending write to 0x20.
    @(negedge clk);
    sel = 1'b0; wen = 4'b1111; addr = 32'h20; wdata = 32'h22222222; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    #1 check("midwait_stall", 32'(stall_a), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_stall", 32'(stall_a), 32'd0);
    check("midrst_resp",  32'(resp_a),  32'd0);
    check("midrst_err",   32'(err_a),   32'd0);
    check("midrst_rdata", rdata_a,      32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_resp", 32'(resp_a), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    run_req(1'b0, 4'b0000, 32'h20, 32'h0, 1'b0, lat, stalls, rd, er);
    check("after_rst_rdata", rd, 32'h11111111);

    // mem_en dropped in the first WAIT cycle: request still completes.
    run_req(1'b0, 4'b1111, 32'h30, 32'h5555AAAA, 1'b1, lat, stalls, rd, er);
    check("drop_lat", 32'(lat), 32'd3);
    check("drop_err", 32'(er),  32'd0);
    run_req(1'b0, 4'b0000, 32'h30, 32'h0, 1'b0, lat, stalls, rd, er);
    check("drop_rdata", rd, 32'h5555AAAA);

    // Zero wait states: one stall cycle, response on the next cycle.
    run_req(1'b1, 4'b1111, 32'h40, 32'h0F0F0F0F, 1'b0, lat, stalls, rd, er);
    check("wc0_lat",   32'(lat),    32'd1);
    check("wc0_stall", 32'(stalls), 32'd1);
    run_req(1'b1, 4'b1111, 32'h44, 32'h99887766, 1'b0, lat, stalls, rd, er);
    check("wc0_lat2", 32'(lat), 32'd1);

    // Held mem_en through RESP, then a back-to-back second read.
    @(negedge clk);
    sel = 1'b1; wen = 4'b0000; addr = 32'h40; en = 1'b1;
    #1;
    check("b2b_req_stall", 32'(stall_b), 32'd1);
    check("b2b_req_resp",  32'(resp_b),  32'd0);
    @(negedge clk);
    #1;
    check("b2b_resp1",       32'(resp_b),  32'd1);
    check("b2b_rdata1",      rdata_b,      32'h0F0F0F0F);
    check("b2b_resp1_stall", 32'(stall_b), 32'd0);
    @(negedge clk);
    addr = 32'h44;
    #1;
    check("b2b_no_reaccept", 32'(resp_b),  32'd0);
    check("b2b_req2_stall",  32'(stall_b), 32'd1);
    @(negedge clk);
    en = 1'b0;
    #1;
    check("b2b_resp2",  32'(resp_b), 32'd1);
    check("b2b_rdata2", rdata_b,     32'h99887766);
    @(negedge clk);
    #1 check("b2b_idle_resp", 32'(resp_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
